// File: rtl/ofs_plat_prim_fifo_fwft_to_rdreq_pkg.sv
// Shared constants and helpers for the show-ahead to rdreq read adapter.
// Width helpers keep the interface and the adapter in agreement.
package ofs_plat_prim_fifo_fwft_to_rdreq_pkg;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 3;

  function automatic int usedw_bits(input int n_entries);
    return $clog2(n_entries) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/ofs_plat_prim_fifo_fwft_to_rdreq_if.sv
// Bundle of the upstream show-ahead port and the downstream rdreq port.
// master: the adapter; slave: the surrounding FIFO source and consumer.
interface ofs_plat_prim_fifo_fwft_to_rdreq_if
  import ofs_plat_prim_fifo_fwft_to_rdreq_pkg::*;
#(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES = 4
);

  localparam int CNT_BITS = usedw_bits(N_ENTRIES);

  logic [N_DATA_BITS-1:0] in_first;
  logic in_notEmpty;
  logic in_deq_en;

  logic rdreq;
  logic [N_DATA_BITS-1:0] q;
  logic q_valid;
  logic rdempty;
  logic [CNT_BITS-1:0] rdusedw;
  logic rdalmost_empty;
  logic underflow;

  modport master (
    input in_first,
    input in_notEmpty,
    output in_deq_en,
    input rdreq,
    output q,
    output q_valid,
    output rdempty,
    output rdusedw,
    output rdalmost_empty,
    output underflow
  );

  modport slave (
    output in_first,
    output in_notEmpty,
    input in_deq_en,
    output rdreq,
    input q,
    input q_valid,
    input rdempty,
    input rdusedw,
    input rdalmost_empty,
    input underflow
  );

endinterface

// File: rtl/ofs_plat_prim_delay_pipe.sv
// Fixed-depth valid+data shift register; only the valids are reset.
// Data rides along unreset since it is ignored whenever its valid is low.
module ofs_plat_prim_delay_pipe #(
  parameter int N_DATA_BITS = 32,
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic [N_DATA_BITS-1:0] in_data,
  output logic out_valid,
  output logic [N_DATA_BITS-1:0] out_data
);

  logic [DEPTH-1:0] valid;
  logic [N_DATA_BITS-1:0] data [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = DEPTH - 1; i > 0; i--) begin
      valid[i] <= valid[i-1];
      data[i] <= data[i-1];
    end
    valid[0] <= in_valid;
    data[0] <= in_data;
    if (reset) begin
      valid <= '0;
    end
  end

  assign out_valid = valid[DEPTH-1];
  assign out_data = data[DEPTH-1];

endmodule

// File: rtl/ofs_plat_prim_fifo_fwft_to_rdreq.sv
// Drains a show-ahead FIFO into a small buffer and serves it through
// a fixed-latency rdreq/q port with megafunction-style status flags.
module ofs_plat_prim_fifo_fwft_to_rdreq
  import ofs_plat_prim_fifo_fwft_to_rdreq_pkg::*;
#(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES = 4,
  parameter int READ_LATENCY = 1,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input logic clk,
  input logic reset,
  ofs_plat_prim_fifo_fwft_to_rdreq_if.master bus
);

  localparam int PTR_BITS = $clog2(N_ENTRIES);
  localparam int CNT_BITS = usedw_bits(N_ENTRIES);

  typedef logic [PTR_BITS-1:0] ptr_t;
  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam cnt_t FULL = cnt_t'(N_ENTRIES);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t cnt;
  logic wr;
  logic rd_acc;
  logic underflow_r;
  logic [N_DATA_BITS-1:0] rd_data;

  // Full uses registered cnt only, so a same-cycle read never frees a slot.
  assign wr = bus.in_notEmpty && (cnt != FULL) && !reset;
  assign rd_acc = bus.rdreq && (cnt != '0);
  assign bus.in_deq_en = wr;

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= bus.in_first;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      underflow_r <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      cnt <= cnt + cnt_t'(wr) - cnt_t'(rd_acc);
      if (bus.rdreq && (cnt == '0)) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_ptr];

  ofs_plat_prim_delay_pipe #(
    .N_DATA_BITS(N_DATA_BITS),
    .DEPTH(READ_LATENCY)
  ) pipe (
    .clk(clk),
    .reset(reset),
    .in_valid(rd_acc),
    .in_data(rd_data),
    .out_valid(bus.q_valid),
    .out_data(bus.q)
  );

  assign bus.rdempty = (cnt == '0);
  assign bus.rdusedw = cnt;
  assign bus.rdalmost_empty = (int'(cnt) <= ALMOST_EMPTY_THRESHOLD);
  assign bus.underflow = underflow_r;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (READ_LATENCY >= MIN_READ_LATENCY &&
            READ_LATENCY <= MAX_READ_LATENCY)
      else $error("READ_LATENCY %0d outside 1..3", READ_LATENCY);
    assert (is_pow2(N_ENTRIES) && N_ENTRIES >= 2)
      else $error("N_ENTRIES %0d not a power of 2 >= 2", N_ENTRIES);
    if (!reset && bus.rdreq && bus.rdempty) begin
      $warning("rdreq while rdempty; request dropped");
    end
  end
`endif

endmodule

// File: tb/tb_ofs_plat_prim_fifo_fwft_to_rdreq.sv
// Bench for the rdreq adapter: three configurations, a queue-based
// reference model, a directed vector table and random traffic.
module tb_ofs_plat_prim_fifo_fwft_to_rdreq;

  localparam int NI = 3;
  localparam int NE [NI] = '{4, 8, 2};
  localparam int LAT [NI] = '{2, 3, 1};
  localparam int AE_THR = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [NI];
  logic ne [NI];
  logic rq [NI];
  logic [31:0] din [NI];
  logic deq [NI];
  logic [31:0] qo [NI];
  logic qv [NI];
  logic emp [NI];
  logic ae [NI];
  logic uf [NI];
  logic [3:0] uw [NI];

  ofs_plat_prim_fifo_fwft_to_rdreq_if #(.N_DATA_BITS(32), .N_ENTRIES(4)) ia ();
  ofs_plat_prim_fifo_fwft_to_rdreq_if #(.N_DATA_BITS(32), .N_ENTRIES(8)) ib ();
  ofs_plat_prim_fifo_fwft_to_rdreq_if #(.N_DATA_BITS(32), .N_ENTRIES(2)) ic ();

  ofs_plat_prim_fifo_fwft_to_rdreq #(
    .N_DATA_BITS(32), .N_ENTRIES(4), .READ_LATENCY(2),
    .ALMOST_EMPTY_THRESHOLD(AE_THR)
  ) dut_a (.clk(clk), .reset(rst[0]), .bus(ia.master));

  ofs_plat_prim_fifo_fwft_to_rdreq #(
    .N_DATA_BITS(32), .N_ENTRIES(8), .READ_LATENCY(3),
    .ALMOST_EMPTY_THRESHOLD(AE_THR)
  ) dut_b (.clk(clk), .reset(rst[1]), .bus(ib.master));

  ofs_plat_prim_fifo_fwft_to_rdreq #(
    .N_DATA_BITS(32), .N_ENTRIES(2), .READ_LATENCY(1),
    .ALMOST_EMPTY_THRESHOLD(AE_THR)
  ) dut_c (.clk(clk), .reset(rst[2]), .bus(ic.master));

  assign ia.in_first = din[0];
  assign ia.in_notEmpty = ne[0];
  assign ia.rdreq = rq[0];
  assign deq[0] = ia.in_deq_en;
  assign qo[0] = ia.q;
  assign qv[0] = ia.q_valid;
  assign emp[0] = ia.rdempty;
  assign ae[0] = ia.rdalmost_empty;
  assign uf[0] = ia.underflow;
  assign uw[0] = {1'b0, ia.rdusedw};

  assign ib.in_first = din[1];
  assign ib.in_notEmpty = ne[1];
  assign ib.rdreq = rq[1];
  assign deq[1] = ib.in_deq_en;
  assign qo[1] = ib.q;
  assign qv[1] = ib.q_valid;
  assign emp[1] = ib.rdempty;
  assign ae[1] = ib.rdalmost_empty;
  assign uf[1] = ib.underflow;
  assign uw[1] = ib.rdusedw;

  assign ic.in_first = din[2];
  assign ic.in_notEmpty = ne[2];
  assign ic.rdreq = rq[2];
  assign deq[2] = ic.in_deq_en;
  assign qo[2] = ic.q;
  assign qv[2] = ic.q_valid;
  assign emp[2] = ic.rdempty;
  assign ae[2] = ic.rdalmost_empty;
  assign uf[2] = ic.underflow;
  assign uw[2] = {2'b00, ic.rdusedw};

  // Reference model: buffered words, in-flight words with due cycle.
  typedef struct {
    int due;
    int d;
  } pe_t;

  int bufq [NI][$];
  pe_t pipeq [NI][$];
  int seq [NI];
  bit ufm [NI];
  bit armed [NI];
  int wrote [NI];
  int got [NI];
  int cyc_n;

  int checks;
  int errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_check(input int k);
    int n;
    bit ev;
    string p;
    p = $sformatf("i%0d_", k);
    if (!armed[k]) begin
      if (rst[k]) chk({p, "deq_in_rst"}, 32'(deq[k]), 0);
      return;
    end
    n = bufq[k].size();
    chk({p, "deq"}, 32'(deq[k]),
        32'(ne[k] && (n != NE[k]) && !rst[k]));
    chk({p, "rdempty"}, 32'(emp[k]), 32'(n == 0));
    chk({p, "rdusedw"}, 32'(uw[k]), 32'(n));
    chk({p, "almost_empty"}, 32'(ae[k]), 32'(n <= AE_THR));
    chk({p, "underflow"}, 32'(uf[k]), 32'(ufm[k]));
    ev = (pipeq[k].size() > 0) && (pipeq[k][0].due == cyc_n);
    chk({p, "q_valid"}, 32'(qv[k]), 32'(ev));
    if (ev) begin
      chk({p, "q"}, qo[k], 32'(pipeq[k][0].d));
      void'(pipeq[k].pop_front());
      got[k]++;
    end
  endtask

  task automatic model_update(input int k);
    int n;
    pe_t e;
    if (rst[k]) begin
      bufq[k].delete();
      pipeq[k].delete();
      ufm[k] = 1'b0;
      armed[k] = 1'b1;
      return;
    end
    if (!armed[k]) return;
    n = bufq[k].size();
    if (rq[k] && n == 0) ufm[k] = 1'b1;
    if (rq[k] && n != 0) begin
      e.due = cyc_n + LAT[k];
      e.d = bufq[k].pop_front();
      pipeq[k].push_back(e);
    end
    if (ne[k] && n != NE[k]) begin
      bufq[k].push_back(seq[k]);
      seq[k]++;
      wrote[k]++;
    end
  endtask

  task automatic step();
    for (int k = 0; k < NI; k++) din[k] = seq[k];
    #1;
    for (int k = 0; k < NI; k++) model_check(k);
    for (int k = 0; k < NI; k++) model_update(k);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < NI; k++) begin
      ne[k] = 1'b0;
      rq[k] = 1'b0;
    end
  endtask

  task automatic drain(input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < NI; k++) begin
        ne[k] = 1'b0;
        rq[k] = (bufq[k].size() != 0);
      end
      step();
    end
    idle_all();
  endtask

  typedef struct {
    bit ne;
    bit rq;
    bit deq;
    int usedw;
    bit qv;
    int q;
  } vec_t;

  vec_t tv [15];

  initial begin
    // Fill 1..6 into a 4-deep buffer, then read 6 back (latency 2).
    tv[0]  = '{1'b1, 1'b0, 1'b1, 0, 1'b0, 0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 0};
    tv[2]  = '{1'b1, 1'b0, 1'b1, 2, 1'b0, 0};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 0};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 0};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 3, 1'b0, 0};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 3, 1'b1, 1};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 2};
    tv[10] = '{1'b0, 1'b1, 1'b0, 2, 1'b1, 3};
    tv[11] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 4};
    tv[12] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 5};
    tv[13] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 6};
    tv[14] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 0};

    checks = 0;
    errors = 0;
    cyc_n = 0;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      ne[k] = 1'b1;
      rq[k] = 1'b0;
      seq[k] = 32'h100 * (k + 1);
      din[k] = seq[k];
      ufm[k] = 1'b0;
      armed[k] = 1'b0;
      wrote[k] = 0;
      got[k] = 0;
    end
    @(negedge clk);

    // Reset held 3 cycles with upstream offering data.
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_deq", 32'(deq[0]), 0);
      if (c > 0) begin
        chk("rst_rdempty", 32'(emp[0]), 1);
        chk("rst_rdusedw", 32'(uw[0]), 0);
        chk("rst_q_valid", 32'(qv[0]), 0);
        chk("rst_almost_empty", 32'(ae[0]), 1);
        chk("rst_underflow", 32'(uf[0]), 0);
      end
      step();
    end
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    #1;
    chk("post_rst_deq", 32'(deq[0]), 1);
    step();
    drain(20);

    // Single word 0xA5 with READ_LATENCY=2.
    seq[0] = 32'hA5;
    ne[0] = 1'b1;
    step();
    ne[0] = 1'b0;
    rq[0] = 1'b1;
    #1;
    chk("a5_rdempty_t1", 32'(emp[0]), 0);
    step();
    rq[0] = 1'b0;
    #1;
    chk("a5_rdempty_t2", 32'(emp[0]), 1);
    chk("a5_q_valid_t2", 32'(qv[0]), 0);
    step();
    #1;
    chk("a5_q_valid_t3", 32'(qv[0]), 1);
    chk("a5_q_t3", qo[0], 32'hA5);
    step();
    drain(4);

    // Vector table: fill to full, pointer wrap, in-order readback.
    seq[0] = 1;
    foreach (tv[r]) begin
      ne[0] = tv[r].ne;
      rq[0] = tv[r].rq;
      #1;
      chk($sformatf("tbl%0d_deq", r), 32'(deq[0]), 32'(tv[r].deq));
      chk($sformatf("tbl%0d_usedw", r), 32'(uw[0]), 32'(tv[r].usedw));
      chk($sformatf("tbl%0d_qv", r), 32'(qv[0]), 32'(tv[r].qv));
      if (tv[r].qv) chk($sformatf("tbl%0d_q", r), qo[0], 32'(tv[r].q));
      step();
    end
    idle_all();
    drain(4);

    // Read while empty: dropped, sticky underflow until reset.
    rq[0] = 1'b1;
    step();
    rq[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("uf_flag", 32'(uf[0]), 1);
      chk("uf_q_valid", 32'(qv[0]), 0);
      chk("uf_rdusedw", 32'(uw[0]), 0);
      step();
    end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    #1;
    chk("uf_cleared", 32'(uf[0]), 0);
    step();

    // Two reads in flight on the latency-3 instance, then reset.
    ne[1] = 1'b1;
    step();
    step();
    ne[1] = 1'b0;
    rq[1] = 1'b1;
    step();
    step();
    rq[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    chk("midrst_deq", 32'(deq[1]), 0);
    step();
    rst[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("midrst_q_valid", 32'(qv[1]), 0);
      chk("midrst_rdusedw", 32'(uw[1]), 0);
      step();
    end

    // Random traffic on all instances, reads gated by !rdempty.
    for (int k = 0; k < NI; k++) begin
      wrote[k] = 0;
      got[k] = 0;
    end
    for (int i = 0; i < 10000; i++) begin
      int pw;
      int pr;
      pw = 20 + 25 * ((i / 2500) % 4);
      pr = 95 - 25 * ((i / 2500) % 4);
      for (int k = 0; k < NI; k++) begin
        ne[k] = ($urandom_range(0, 99) < pw);
        rq[k] = ($urandom_range(0, 99) < pr) && (bufq[k].size() != 0);
      end
      step();
    end
    drain(20);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d_delivered", k), 32'(got[k]), 32'(wrote[k]));
      chk($sformatf("i%0d_no_underflow", k), 32'(uf[k]), 0);
      chk($sformatf("i%0d_final_empty", k), 32'(emp[k]), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
